// File: rtl/ring_monitor_if.sv
// Handshake bundle between the upstream ring counter/status sink and ring_monitor.
// master drives sample enable and ring vector; slave (the monitor) returns status.
interface ring_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [15:0]      r_in;
  logic [3:0]       idx;
  logic             valid;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, r_in,
    input  idx, valid, locked, err, err_cnt
  );

  modport slave (
    input  en, r_in,
    output idx, valid, locked, err, err_cnt
  );
endinterface

// File: rtl/ring_monitor.sv
// One-hot ring counter checker: decodes the ring vector, tracks the expected
// index, acquires/drops lock and counts misses while locked.
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | waiting for any valid one-hot sample to seed the tracker
// TRACK   | counting consecutive in-sequence samples toward LOCK_N
// LOCKED  | flywheel on exp; misses pulse err, LOSS_N in a row drop lock
module ring_monitor #(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           RST,
  ring_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TC = 4'(LOCK_N);
  localparam logic [3:0] LOSS_TC = 4'(LOSS_N);

  state_t           r_state;
  logic [3:0]       r_exp;
  logic [3:0]       r_match_cnt;
  logic [3:0]       r_miss_cnt;
  logic [3:0]       r_idx;
  logic             r_valid;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic       w_onehot;
  logic [3:0] w_index;
  logic       w_hit;

  // x & (x-1) clears the lowest set bit, so zero result plus nonzero input means one bit
  always_comb begin
    w_onehot = (bus.r_in != 16'd0) && ((bus.r_in & (bus.r_in - 16'd1)) == 16'd0);
    w_index  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (bus.r_in[i]) w_index = 4'(i);
    end
    w_hit = w_onehot && (w_index == r_exp);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= SEARCH;
      r_exp       <= 4'd0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_idx       <= 4'd0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else if (bus.en) begin
      r_valid <= w_onehot;
      r_err   <= 1'b0;
      if (w_onehot) r_idx <= w_index;

      unique case (r_state)
        SEARCH: begin
          if (w_onehot) begin
            r_state     <= TRACK;
            r_match_cnt <= 4'd1;
            r_exp       <= w_index + 4'd1;
          end
        end

        TRACK: begin
          if (w_hit) begin
            r_match_cnt <= r_match_cnt + 4'd1;
            r_exp       <= r_exp + 4'd1;
            if (r_match_cnt + 4'd1 == LOCK_TC) begin
              r_state    <= LOCKED;
              r_locked   <= 1'b1;
              r_miss_cnt <= 4'd0;
            end
          end else if (w_onehot) begin
            r_match_cnt <= 4'd1;
            r_exp       <= w_index + 4'd1;
          end else begin
            r_state     <= SEARCH;
            r_match_cnt <= 4'd0;
          end
        end

        LOCKED: begin
          // exp free-runs so a single glitch does not shift the expected phase
          r_exp <= r_exp + 4'd1;
          if (w_hit) begin
            r_miss_cnt <= 4'd0;
          end else begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (r_miss_cnt + 4'd1 == LOSS_TC) begin
              r_state     <= SEARCH;
              r_locked    <= 1'b0;
              r_miss_cnt  <= 4'd0;
              r_match_cnt <= 4'd0;
            end else begin
              r_miss_cnt <= r_miss_cnt + 4'd1;
            end
          end
        end

        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end else begin
      r_err <= 1'b0;
    end
  end

  assign bus.idx     = r_idx;
  assign bus.valid   = r_valid;
  assign bus.locked  = r_locked;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: directed vector table, hand-written corner sequences,
// then randomized ring traffic against a sequence-level reference model.
module tb_ring_monitor;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_monitor_if #(.CNT_W(CNT_W)) bus ();

  ring_monitor #(
    .LOCK_N(LOCK_N),
    .LOSS_N(LOSS_N),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] rin;
    logic [3:0]  idx;
    logic        valid;
    logic        locked;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  // reference model state: run length of in-sequence samples, lock flag, miss streak
  int m_idx, m_valid, m_locked, m_err, m_cnt, m_exp, m_run, m_miss;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [15:0] rin,
                     input int idx, input int v, input int l, input int er, input int c);
    vec_t t;
    t.rst = r; t.en = e; t.rin = rin;
    t.idx = 4'(idx); t.valid = v[0]; t.locked = l[0]; t.err = er[0]; t.cnt = 8'(c);
    vecs.push_back(t);
  endtask

  task automatic model(input logic r, input logic e, input logic [15:0] rin);
    int  ones, pos;
    bit  hit;
    if (r) begin
      m_idx = 0; m_valid = 0; m_locked = 0; m_err = 0; m_cnt = 0;
      m_exp = 0; m_run = 0; m_miss = 0;
    end else if (!e) begin
      m_err = 0;
    end else begin
      ones = $countones(rin);
      pos = 0;
      for (int i = 0; i < 16; i++) if (rin[i]) pos = i;
      m_err = 0;
      m_valid = (ones == 1);
      if (ones == 1) m_idx = pos;
      hit = (ones == 1) && (pos == m_exp);
      if (m_locked != 0) begin
        m_exp = (m_exp + 1) % 16;
        if (hit) m_miss = 0;
        else begin
          m_err = 1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          m_miss++;
          if (m_miss >= LOSS_N) begin
            m_locked = 0; m_miss = 0; m_run = 0;
          end
        end
      end else if (ones != 1) begin
        m_run = 0;
      end else if (m_run > 0 && hit) begin
        m_run++;
        m_exp = (m_exp + 1) % 16;
        if (m_run >= LOCK_N) begin
          m_locked = 1; m_miss = 0;
        end
      end else begin
        m_run = 1;
        m_exp = (pos + 1) % 16;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [15:0] rin);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.r_in = rin;
    model(r, e, rin);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d.idx", cyc),    int'(bus.idx),     m_idx);
    chk($sformatf("rnd%0d.valid", cyc),  int'(bus.valid),   m_valid);
    chk($sformatf("rnd%0d.locked", cyc), int'(bus.locked),  m_locked);
    chk($sformatf("rnd%0d.err", cyc),    int'(bus.err),     m_err);
    chk($sformatf("rnd%0d.err_cnt", cyc), int'(bus.err_cnt), m_cnt);
  endtask

  task automatic lock_seq();
    step(1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'h0001);
    step(1'b0, 1'b1, 16'h0002);
    step(1'b0, 1'b1, 16'h0004);
    step(1'b0, 1'b1, 16'h0008);
  endtask

  initial begin
    logic [15:0] one;
    logic [15:0] rin;
    int e, ptr, sel;
    logic r, en;
    one = 16'h0001;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.r_in = 16'h0000;

    // lock acquisition, wrap, enable gating
    add(1, 1, 16'h0001, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0001, 0, 1, 0, 0, 0);
    add(0, 1, 16'h0002, 1, 1, 0, 0, 0);
    add(0, 1, 16'h0004, 2, 1, 0, 0, 0);
    add(0, 1, 16'h0008, 3, 1, 1, 0, 0);
    for (int k = 4; k < 20; k++) add(0, 1, one << (k % 16), k % 16, 1, 1, 0, 0);
    add(0, 0, 16'h1234, 3, 1, 1, 0, 0);
    add(0, 0, 16'h0000, 3, 1, 1, 0, 0);
    add(0, 0, 16'h0040, 3, 1, 1, 0, 0);
    // reseed in TRACK: run restarts at 0x0100
    add(1, 1, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0001, 0, 1, 0, 0, 0);
    add(0, 1, 16'h0002, 1, 1, 0, 0, 0);
    add(0, 1, 16'h0100, 8, 1, 0, 0, 0);
    add(0, 1, 16'h0200, 9, 1, 0, 0, 0);
    add(0, 1, 16'h0400, 10, 1, 0, 0, 0);
    add(0, 1, 16'h0800, 11, 1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].rin);
      chk($sformatf("v%0d.idx", i),     int'(bus.idx),     int'(vecs[i].idx));
      chk($sformatf("v%0d.valid", i),   int'(bus.valid),   int'(vecs[i].valid));
      chk($sformatf("v%0d.locked", i),  int'(bus.locked),  int'(vecs[i].locked));
      chk($sformatf("v%0d.err", i),     int'(bus.err),     int'(vecs[i].err));
      chk($sformatf("v%0d.err_cnt", i), int'(bus.err_cnt), int'(vecs[i].cnt));
    end

    // single glitch while locked
    lock_seq();
    step(1'b0, 1'b1, 16'h0000);
    chk("glitch.err", int'(bus.err), 1);
    chk("glitch.err_cnt", int'(bus.err_cnt), 1);
    chk("glitch.valid", int'(bus.valid), 0);
    chk("glitch.locked", int'(bus.locked), 1);
    chk("glitch.idx", int'(bus.idx), 3);
    step(1'b0, 1'b1, 16'h0020);
    chk("resume.err", int'(bus.err), 0);
    chk("resume.idx", int'(bus.idx), 5);
    chk("resume.locked", int'(bus.locked), 1);
    chk("resume.err_cnt", int'(bus.err_cnt), 1);

    // loss of lock
    lock_seq();
    step(1'b0, 1'b1, 16'h0003);
    chk("loss1.err", int'(bus.err), 1);
    chk("loss1.locked", int'(bus.locked), 1);
    step(1'b0, 1'b1, 16'h0003);
    chk("loss2.err", int'(bus.err), 1);
    chk("loss2.err_cnt", int'(bus.err_cnt), 2);
    chk("loss2.locked", int'(bus.locked), 0);
    step(1'b0, 1'b1, 16'h0010);
    chk("retrack.idx", int'(bus.idx), 4);
    chk("retrack.valid", int'(bus.valid), 1);
    chk("retrack.locked", int'(bus.locked), 0);
    chk("retrack.err", int'(bus.err), 0);

    // saturation: alternate miss/hit so lock is never lost
    lock_seq();
    e = 4;
    for (int k = 0; k < 260; k++) begin
      step(1'b0, 1'b1, 16'h0000);
      if (k == 99)  chk("sat.cnt100", int'(bus.err_cnt), 100);
      if (k == 254) chk("sat.cnt255", int'(bus.err_cnt), 255);
      e = (e + 1) % 16;
      step(1'b0, 1'b1, one << e);
      e = (e + 1) % 16;
    end
    step(1'b0, 1'b1, 16'h0000);
    chk("sat.final_cnt", int'(bus.err_cnt), 255);
    chk("sat.locked", int'(bus.locked), 1);
    chk("sat.err_before_rst", int'(bus.err), 1);
    step(1'b1, 1'b1, 16'h0000);
    chk("rst.idx", int'(bus.idx), 0);
    chk("rst.valid", int'(bus.valid), 0);
    chk("rst.locked", int'(bus.locked), 0);
    chk("rst.err", int'(bus.err), 0);
    chk("rst.err_cnt", int'(bus.err_cnt), 0);

    // randomized ring traffic against the model
    step(1'b1, 1'b1, 16'h0000);
    ptr = 0;
    for (int c = 0; c < 3000; c++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 85) begin
        rin = one << ptr;
        ptr = (ptr + 1) % 16;
      end else if (sel < 90) begin
        rin = 16'h0000;
      end else if (sel < 94) begin
        rin = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
      end else if (sel < 97) begin
        rin = 16'h0001;
        ptr = 1;
      end else begin
        ptr = int'($urandom_range(0, 15));
        rin = one << ptr;
        ptr = (ptr + 1) % 16;
      end
      en = ($urandom_range(0, 99) >= 8);
      r  = ($urandom_range(0, 999) < 5);
      step(r, en, rin);
      check_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
